burst_serializer: RTL and testbench

- Upstream feeder for the serial-to-parallel word assembler on the MRAM write path.
- Accepts parallel BUS_WIDTH words over a valid/ready handshake and buffers them in a small FIFO.
- On command, streams a burst of burst_len words out LSB-first, one bit per clock, with a bit strobe.
- Pulses send_data once the assembler holds each complete word, and burst_done when the burst ends.

---
 rtl/burst_serializer.sv | 152 +++++++++++++++
 tb/tb_burst_serializer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_serializer.sv
// Buffers parallel words in a small FIFO and streams bursts of them LSB-first,
// one bit per clock, framing each word with send_data for the downstream assembler.
module burst_serializer #(
    parameter int BUS_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [BUS_WIDTH-1:0]               in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               start,
    input  logic [LEN_WIDTH-1:0]               burst_len,
    input  logic                               abort,
    output logic                               ser_data,
    output logic                               ser_en,
    output logic                               send_data,
    output logic                               busy,
    output logic                               burst_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(BUS_WIDTH) + 1;
    localparam logic [LVL_W-1:0]     FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(BUS_WIDTH - 1);
    localparam logic [LEN_WIDTH-1:0] ONE_LEFT = LEN_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, WAIT, SHIFT, NOTIFY} state_t;

    state_t               state;
    logic [BUS_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [LVL_W-1:0]     level;
    logic [BUS_WIDTH-1:0] head;
    logic [BUS_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [LEN_WIDTH-1:0] words_left;
    logic                 push, pop;

    // in_ready comes from the registered level only, so it never depends on a pop.
    assign in_ready   = (level != FULL_LVL);
    assign fifo_level = level;
    assign head       = mem[rd_ptr];
    assign push       = in_valid && in_ready && !abort;
    assign ser_data   = ser_en & shreg[0];

    always_comb begin
        pop = 1'b0;
        if (!abort && level != '0) begin
            case (state)
                WAIT:    pop = 1'b1;
                NOTIFY:  pop = (words_left != ONE_LEFT);
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            words_left <= '0;
            ser_en     <= 1'b0;
            send_data  <= 1'b0;
            burst_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            send_data  <= 1'b0;
            burst_done <= 1'b0;
            if (abort) begin
                state  <= IDLE;
                ser_en <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (burst_len != '0) begin
                                words_left <= burst_len;
                                state      <= WAIT;
                                busy       <= 1'b1;
                            end else begin
                                burst_done <= 1'b1;
                            end
                        end
                    end
                    WAIT: begin
                        if (pop) begin
                            shreg   <= head;
                            bit_cnt <= '0;
                            state   <= SHIFT;
                            ser_en  <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            // Pulses are registered on entry so they line up with NOTIFY.
                            state      <= NOTIFY;
                            ser_en     <= 1'b0;
                            send_data  <= 1'b1;
                            burst_done <= (words_left == ONE_LEFT);
                        end
                    end
                    NOTIFY: begin
                        words_left <= words_left - ONE_LEFT;
                        if (words_left == ONE_LEFT) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (pop) begin
                            shreg   <= head;
                            bit_cnt <= '0;
                            state   <= SHIFT;
                            ser_en  <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_burst_serializer.sv
// Directed and randomized checks of burst_serializer against a word-queue reference
// model; a negedge monitor rebuilds words from the serial stream.
module tb_burst_serializer;
    localparam int W  = 16;
    localparam int D  = 4;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          abort = 1'b0;
    logic          ser_data, ser_en, send_data, busy, burst_done;
    logic [$clog2(D+1)-1:0] fifo_level;

    burst_serializer #(.BUS_WIDTH(W), .FIFO_DEPTH(D), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .start(start), .burst_len(burst_len), .abort(abort), .ser_data(ser_data),
        .ser_en(ser_en), .send_data(send_data), .busy(busy), .burst_done(burst_done),
        .fifo_level(fifo_level)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: plays the role of the downstream assembler
    logic [W-1:0] asm_reg = '0;
    logic         en_prev = 1'b0;
    logic         bits_q[$];
    logic [W-1:0] got_q[$];
    int           rise_q[$];
    int           en_cnt = 0, send_cnt = 0, done_cnt = 0, done_cyc = 0;
    logic         done_with_send = 1'b0;

    always @(negedge clk) begin
        if (ser_en) begin
            asm_reg <= {ser_data, asm_reg[W-1:1]};
            bits_q.push_back(ser_data);
            en_cnt  <= en_cnt + 1;
            if (!en_prev) rise_q.push_back(cyc);
        end
        en_prev <= ser_en;
        if (send_data) begin
            got_q.push_back(asm_reg);
            send_cnt <= send_cnt + 1;
        end
        if (burst_done) begin
            done_cnt       <= done_cnt + 1;
            done_cyc       <= cyc;
            done_with_send <= send_data;
        end
    end

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int tests = 0, fails = 0;
    int gb, bb, eb, sb, db, rb, start_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        gb = got_q.size(); bb = bits_q.size(); eb = en_cnt;
        sb = send_cnt;     db = done_cnt;      rb = rise_q.size();
        exp_q.delete();
    endtask

    task automatic push_word(input logic [W-1:0] w);
        int t = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && t < 300) begin
            tick();
            t++;
        end
        check("push_timeout", 32'(t < 300), 1);
        tick();
        in_valid = 1'b0;
        exp_q.push_back(w);
    endtask

    task automatic start_burst(input int len);
        start     = 1'b1;
        burst_len = LW'(len);
        start_cyc = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (done_cnt == db && t < budget) begin
            tick();
            t++;
        end
        check("done_timeout", 32'(done_cnt != db), 1);
    endtask

    task automatic check_burst(input string tag, input int len);
        tick(2);
        check({tag, "_sends"}, 32'(send_cnt - sb), 32'(len));
        check({tag, "_dones"}, 32'(done_cnt - db), 1);
        check({tag, "_en_cycles"}, 32'(en_cnt - eb), 32'(W * len));
        check({tag, "_level"}, 32'(fifo_level), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        for (int i = 0; i < len; i++)
            check($sformatf("%s_word%0d", tag, i), 32'(got_q[gb + i]), 32'(exp_q[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] bitsv;
        logic [W-1:0] w1, w2;
        int n, len, acc;

        // reset values
        tick(3);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_ser_en", 32'(ser_en), 0);
        check("rst_ser_data", 32'(ser_data), 0);
        check("rst_send", 32'(send_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(burst_done), 0);
        check("rst_level", 32'(fifo_level), 0);
        rst = 1'b0;
        tick(2);

        // single preloaded word, bit order and latency
        snap();
        push_word(16'hA5C3);
        check("A_level", 32'(fifo_level), 1);
        start_burst(1);
        wait_done(100);
        for (int i = 0; i < W; i++) bitsv[i] = bits_q[bb + i];
        check("A_bits", 32'(bitsv), 32'h0000A5C3);
        check("A_first_bit_lat", 32'(rise_q[rb] - start_cyc), 2);
        check("A_done_lat", 32'(done_cyc - rise_q[rb]), 16);
        check("A_done_with_send", 32'(done_with_send), 1);
        check_burst("A", 1);

        // four words, gapless 17-cycle framing
        snap();
        push_word(16'h0001); push_word(16'h8000); push_word(16'hFFFF); push_word(16'h1234);
        check("B_level", 32'(fifo_level), 4);
        start_burst(4);
        wait_done(300);
        check("B_first_bit_lat", 32'(rise_q[rb] - start_cyc), 2);
        for (int i = 0; i < 3; i++)
            check($sformatf("B_frame%0d", i), 32'(rise_q[rb + i + 1] - rise_q[rb + i]), 17);
        check("B_done_lat", 32'(done_cyc - rise_q[rb]), 67);
        check_burst("B", 4);

        // empty FIFO: stall in WAIT, words trickle in
        snap();
        start_burst(3);
        tick(20);
        check("C_stall_en", 32'(ser_en), 0);
        check("C_stall_busy", 32'(busy), 1);
        fork
            begin
                tick(20);
                push_word(W'($urandom));
                repeat (2) begin
                    tick(39);
                    push_word(W'($urandom));
                end
            end
            wait_done(600);
        join
        check_burst("C", 3);

        // full FIFO refuses the fifth word
        snap();
        acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = W'($urandom);
            if (acc < D) begin
                exp_q.push_back(in_data);
                acc++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("D_full_level", 32'(fifo_level), 4);
        check("D_full_ready", 32'(in_ready), 0);
        start_burst(4);
        wait_done(300);
        check_burst("D", 4);

        // push and pop in the same cycle
        snap();
        start_burst(2);
        tick(3);
        w1 = W'($urandom); w2 = W'($urandom);
        in_data = w1; in_valid = 1'b1;
        tick();
        exp_q.push_back(w1);
        check("E_level_after_push", 32'(fifo_level), 1);
        in_data = w2;
        tick();
        exp_q.push_back(w2);
        in_valid = 1'b0;
        check("E_level_push_pop", 32'(fifo_level), 1);
        check("E_shifting", 32'(ser_en), 1);
        wait_done(200);
        check_burst("E", 2);

        // abort at bit 7 of word 2, with a push in the abort cycle
        snap();
        for (int i = 0; i < 4; i++) push_word(W'($urandom));
        start_burst(4);
        tick(25);
        abort = 1'b1; in_valid = 1'b1; in_data = W'($urandom);
        tick();
        abort = 1'b0; in_valid = 1'b0;
        check("F_en", 32'(ser_en), 0);
        check("F_level", 32'(fifo_level), 0);
        check("F_busy", 32'(busy), 0);
        check("F_bits_sent", 32'(en_cnt - eb), 24);
        tick(30);
        check("F_no_done", 32'(done_cnt - db), 0);
        check("F_sends", 32'(send_cnt - sb), 1);
        check("F_level_later", 32'(fifo_level), 0);
        check("F_word0", 32'(got_q[gb]), 32'(exp_q[0]));

        // reset mid-SHIFT, then zero-length burst
        snap();
        push_word(W'($urandom));
        start_burst(1);
        tick(8);
        rst = 1'b1;
        #1;
        check("G_rst_en", 32'(ser_en), 0);
        check("G_rst_data", 32'(ser_data), 0);
        check("G_rst_send", 32'(send_data), 0);
        check("G_rst_busy", 32'(busy), 0);
        check("G_rst_level", 32'(fifo_level), 0);
        check("G_rst_ready", 32'(in_ready), 1);
        tick(2);
        rst = 1'b0;
        tick(5);
        check("G_no_done", 32'(done_cnt - db), 0);
        snap();
        start_burst(0);
        check("G_zero_done_pulse", 32'(burst_done), 1);
        tick(5);
        check("G_zero_dones", 32'(done_cnt - db), 1);
        check("G_zero_no_en", 32'(en_cnt - eb), 0);
        check("G_zero_busy", 32'(busy), 0);

        // randomized bursts with partial preload and random feed gaps
        for (int it = 0; it < 5; it++) begin
            snap();
            len = $urandom_range(1, 6);
            n = $urandom_range(0, (len < D) ? len : D);
            for (int i = 0; i < n; i++) push_word(W'($urandom));
            start_burst(len);
            fork
                for (int i = n; i < len; i++) begin
                    tick($urandom_range(0, 25));
                    push_word(W'($urandom));
                end
                wait_done(3000);
            join
            check_burst($sformatf("R%0d", it), len);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
